// File: rtl/vm_coin_front.sv
// -----------------------------------------------------------------------------
// vm_coin_front
//
// Front-end stage for the vending FSM. It conditions the raw user buttons,
// keeps the coin credit, tells the downstream FSM when enough credit has been
// inserted, deducts the price once a beverage is dispensed, and pays back any
// refunded credit one unit per cycle.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   coin_valid   in   single-cycle coin-accepted strobe (clk domain)
//   coin_val     in   coin value in units, qualified by coin_valid (0 = ignore)
//   sel_btn      in   raw asynchronous selection button level
//   refund_btn   in   raw asynchronous refund button level
//   beverage     in   dispense indication from the downstream FSM
//   coin         out  single-cycle pulse: credit covers the price
//   selection    out  single-cycle pulse: user selected
//   refund       out  single-cycle pulse: user cancelled after arming
//   credit       out  current credit
//   change_pulse out  one cycle high per unit returned
//   change_busy  out  high while change is being paid out
//   coin_reject  out  single-cycle pulse: coin refused
// -----------------------------------------------------------------------------
module vm_coin_front #(
   parameter int PRICE        = 5,
   parameter int CREDIT_W     = 4,
   parameter int MAX_CREDIT   = 15,
   parameter int VEND_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [2:0]          coin_val,
   input  logic                sel_btn,
   input  logic                refund_btn,
   input  logic                beverage,
   output logic                coin,
   output logic                selection,
   output logic                refund,
   output logic [CREDIT_W-1:0] credit,
   output logic                change_pulse,
   output logic                change_busy,
   output logic                coin_reject
);

   localparam int SUM_W = CREDIT_W + 1;
   localparam int CNT_W = $clog2(VEND_TIMEOUT + 1);

   localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
   localparam logic [SUM_W-1:0]    MAX_C        = SUM_W'(MAX_CREDIT);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(VEND_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_ACCUM     = 2'd0,
      ST_ARMED     = 2'd1,
      ST_VEND_WAIT = 2'd2,
      ST_CHANGE    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Button conditioning: two synchronizer stages plus one edge-history stage.
   logic sel_s1_q, sel_s2_q, sel_s3_q;
   logic ref_s1_q, ref_s2_q, ref_s3_q;

   logic coin_q, coin_d;
   logic selection_q, selection_d;
   logic refund_q, refund_d;
   logic change_pulse_q, change_pulse_d;
   logic change_busy_q, change_busy_d;
   logic coin_reject_q, coin_reject_d;

   logic                sel_edge, refund_edge;
   logic                coin_seen, coin_fits, coin_bad;
   logic [SUM_W-1:0]    credit_sum;
   logic [CREDIT_W-1:0] credit_add;

   assign sel_edge    = sel_s2_q & ~sel_s3_q;
   assign refund_edge = ref_s2_q & ~ref_s3_q;

   // A zero-valued coin is treated as no coin at all: neither added nor rejected.
   assign coin_seen  = coin_valid && (coin_val != 3'd0);
   assign credit_sum = {1'b0, credit_q} + SUM_W'(coin_val);
   assign coin_fits  = (credit_sum <= MAX_C);
   assign coin_bad   = coin_seen && !coin_fits;
   // Credit after this cycle's coin, for the states that accept coins.
   assign credit_add = (coin_seen && coin_fits) ? credit_sum[CREDIT_W-1:0] : credit_q;

   // ---------------------------------------------------------------------------
   // State register (all flops, including the registered outputs)
   // ---------------------------------------------------------------------------
   // NOTE: every flop uses non-blocking assignment so all registers update from
   // the same pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_ACCUM;
         credit_q       <= '0;
         cnt_q          <= '0;
         sel_s1_q       <= 1'b0;
         sel_s2_q       <= 1'b0;
         sel_s3_q       <= 1'b0;
         ref_s1_q       <= 1'b0;
         ref_s2_q       <= 1'b0;
         ref_s3_q       <= 1'b0;
         coin_q         <= 1'b0;
         selection_q    <= 1'b0;
         refund_q       <= 1'b0;
         change_pulse_q <= 1'b0;
         change_busy_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         cnt_q          <= cnt_d;
         sel_s1_q       <= sel_btn;
         sel_s2_q       <= sel_s1_q;
         sel_s3_q       <= sel_s2_q;
         ref_s1_q       <= refund_btn;
         ref_s2_q       <= ref_s1_q;
         ref_s3_q       <= ref_s2_q;
         coin_q         <= coin_d;
         selection_q    <= selection_d;
         refund_q       <= refund_d;
         change_pulse_q <= change_pulse_d;
         change_busy_q  <= change_busy_d;
         coin_reject_q  <= coin_reject_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_ACCUM: begin
            credit_d = credit_add;
            // Downstream is idle here, so a refund goes straight to payout.
            if (refund_edge && (credit_add != '0)) begin
               state_d = ST_CHANGE;
            end else if (credit_add >= PRICE_C) begin
               // Covers both a fresh coin and leftover credit from a vend.
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // The coin is added first; a refund then returns the whole credit.
            credit_d = credit_add;
            if (refund_edge) begin
               state_d = ST_CHANGE;
            end else if (sel_edge) begin
               state_d = ST_VEND_WAIT;
               cnt_d   = '0;
            end
         end
         ST_VEND_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (beverage) begin
               credit_d = credit_q - PRICE_C;
               state_d  = ST_ACCUM;
            end else if (cnt_q == TIMEOUT_LAST) begin
               // Downstream never answered: give the customer everything back.
               state_d = ST_CHANGE;
            end
         end
         ST_CHANGE: begin
            if (credit_q != '0) begin
               credit_d = credit_q - CREDIT_W'(1);
            end else begin
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // ---------------------------------------------------------------------------
   always_comb begin
      coin_d         = 1'b0;
      selection_d    = 1'b0;
      refund_d       = 1'b0;
      change_pulse_d = 1'b0;
      coin_reject_d  = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            coin_reject_d = coin_bad;
            coin_d        = !(refund_edge && (credit_add != '0)) && (credit_add >= PRICE_C);
         end
         ST_ARMED: begin
            coin_reject_d = coin_bad;
            refund_d      = refund_edge;
            selection_d   = sel_edge && !refund_edge;
         end
         ST_VEND_WAIT: begin
            coin_reject_d = coin_seen;
         end
         ST_CHANGE: begin
            coin_reject_d  = coin_seen;
            change_pulse_d = (credit_q != '0);
         end
         default: begin
            coin_reject_d = 1'b0;
         end
      endcase
      change_busy_d = (state_d == ST_CHANGE);
   end

   assign coin         = coin_q;
   assign selection    = selection_q;
   assign refund       = refund_q;
   assign credit       = credit_q;
   assign change_pulse = change_pulse_q;
   assign change_busy  = change_busy_q;
   assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vm_coin_front.sv
// -----------------------------------------------------------------------------
// tb_vm_coin_front
//
// Self-checking bench for vm_coin_front. A behavioural model of the vending
// front end runs in lockstep with the DUT; every output is compared after
// every clock edge, first through a directed scenario sequence and then under
// randomized stimulus.
// -----------------------------------------------------------------------------
module tb_vm_coin_front;

   localparam int PRICE   = 5;
   localparam int MAXC    = 15;
   localparam int TIMEOUT = 4;

   localparam int M_ACCUM  = 0;
   localparam int M_ARMED  = 1;
   localparam int M_WAIT   = 2;
   localparam int M_CHANGE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [2:0] coin_val;
   logic       sel_btn;
   logic       refund_btn;
   logic       beverage;
   logic       coin;
   logic       selection;
   logic       refund;
   logic [3:0] credit;
   logic       change_pulse;
   logic       change_busy;
   logic       coin_reject;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   int m_mode;
   int m_credit;
   int m_wait;
   bit sel_hist [3];   // button levels seen on the last three edges, newest first
   bit ref_hist [3];
   bit e_coin, e_sel, e_ref, e_chg, e_busy, e_rej;

   vm_coin_front dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_btn      (sel_btn),
      .refund_btn   (refund_btn),
      .beverage     (beverage),
      .coin         (coin),
      .selection    (selection),
      .refund       (refund),
      .credit       (credit),
      .change_pulse (change_pulse),
      .change_busy  (change_busy),
      .coin_reject  (coin_reject)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit sel_e, ref_e, coin_in;
      e_coin = 0; e_sel = 0; e_ref = 0; e_chg = 0; e_rej = 0;
      if (rst) begin
         m_mode   = M_ACCUM;
         m_credit = 0;
         m_wait   = 0;
         e_busy   = 0;
         for (int i = 0; i < 3; i++) begin
            sel_hist[i] = 0;
            ref_hist[i] = 0;
         end
         return;
      end
      // A button edge is acted on two edges after its rising level is first seen.
      sel_e   = sel_hist[1] && !sel_hist[2];
      ref_e   = ref_hist[1] && !ref_hist[2];
      sel_hist[2] = sel_hist[1]; sel_hist[1] = sel_hist[0]; sel_hist[0] = sel_btn;
      ref_hist[2] = ref_hist[1]; ref_hist[1] = ref_hist[0]; ref_hist[0] = refund_btn;
      coin_in = coin_valid && (coin_val != 0);

      if (m_mode == M_ACCUM || m_mode == M_ARMED) begin
         if (coin_in) begin
            if (m_credit + int'(coin_val) <= MAXC) m_credit += int'(coin_val);
            else e_rej = 1;
         end
         if (m_mode == M_ACCUM) begin
            if (ref_e && m_credit > 0) m_mode = M_CHANGE;
            else if (m_credit >= PRICE) begin
               e_coin = 1;
               m_mode = M_ARMED;
            end
         end else begin
            if (ref_e) begin
               e_ref  = 1;
               m_mode = M_CHANGE;
            end else if (sel_e) begin
               e_sel  = 1;
               m_mode = M_WAIT;
               m_wait = 0;
            end
         end
      end else if (m_mode == M_WAIT) begin
         e_rej = coin_in;
         m_wait++;
         if (beverage) begin
            m_credit -= PRICE;
            m_mode = M_ACCUM;
         end else if (m_wait >= TIMEOUT) begin
            m_mode = M_CHANGE;
         end
      end else begin
         e_rej = coin_in;
         if (m_credit > 0) begin
            e_chg = 1;
            m_credit--;
         end else begin
            m_mode = M_ACCUM;
         end
      end
      e_busy = (m_mode == M_CHANGE);
   endtask

   // One clock: model and DUT both take the edge, outputs compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("credit",       int'(credit),       m_credit);
      check("coin",         int'(coin),         int'(e_coin));
      check("selection",    int'(selection),    int'(e_sel));
      check("refund",       int'(refund),       int'(e_ref));
      check("change_pulse", int'(change_pulse), int'(e_chg));
      check("change_busy",  int'(change_busy),  int'(e_busy));
      check("coin_reject",  int'(coin_reject),  int'(e_rej));
      check("pulse_excl",   int'(coin) + int'(selection) + int'(refund) <= 1 ? 1 : 0, 1);
   endtask

   initial begin
      rst = 1; coin_valid = 1; coin_val = 3'd3;
      sel_btn = 0; refund_btn = 0; beverage = 0;

      // Reset held two cycles with a coin strobe present.
      tick(); tick();
      rst = 0;

      // 3 + 2 reaches the price: coin pulse, armed. Another 2 gives credit 7.
      coin_val = 3'd3; tick();
      coin_val = 3'd2; tick();
      coin_val = 3'd2; tick();
      coin_valid = 0;

      // Selection with nominal downstream: beverage one cycle after selection.
      sel_btn = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (e_sel) break;
      end
      tick();
      beverage = 1; tick();
      beverage = 0; sel_btn = 0;
      repeat (3) tick();

      // Credit 2 + 4 = 6, armed; select and refund together: refund wins, payout 6.
      coin_valid = 1; coin_val = 3'd4; tick();
      coin_valid = 0;
      sel_btn = 1; refund_btn = 1;
      repeat (10) tick();
      sel_btn = 0; refund_btn = 0;
      repeat (3) tick();

      // Build 13, then an over-limit coin is rejected; coins rejected during payout.
      coin_valid = 1; coin_val = 3'd7; tick();
      coin_val = 3'd6; tick();
      coin_val = 3'd4; tick();
      coin_valid = 0; refund_btn = 1;
      repeat (3) tick();
      coin_valid = 1; coin_val = 3'd1; tick();
      coin_valid = 0; refund_btn = 0;
      repeat (16) tick();

      // Selection with no beverage: timeout, then full credit returned.
      coin_valid = 1; coin_val = 3'd5; tick();
      coin_valid = 0; sel_btn = 1;
      repeat (8) tick();
      sel_btn = 0;
      repeat (8) tick();

      // Reset in the middle of a payout with 4 units still owed.
      coin_valid = 1; coin_val = 3'd7; tick();
      coin_valid = 0; refund_btn = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m_mode == M_CHANGE && m_credit == 4) break;
      end
      rst = 1; refund_btn = 0; tick();
      rst = 0; repeat (3) tick();

      // Randomized stimulus.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         coin_valid = ($urandom_range(0, 9) < 3);
         coin_val   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0)  sel_btn    = ~sel_btn;
         if ($urandom_range(0, 19) == 0) refund_btn = ~refund_btn;
         beverage   = ($urandom_range(0, 9) < 3);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
